// File: rtl/cflog_reader.sv
`default_nettype none
// ============================================================================
// Module      : cflog_reader
// Description : Reads the CF-Log RAM from word 0 up to the captured log
//               pointer and streams it as 16-bit words over valid/ready:
//               header (entry count), entries, XOR checksum trailer.
// Ports       : clk, reset (async, active-high)
//               flush/log_ptr/abort : control from the log monitor
//               mem_rd_en/mem_addr/mem_rd_data : CF-Log RAM read port
//                 (read data valid one cycle after mem_rd_en)
//               out_valid/out_ready/out_data/out_last : output stream
//               busy : readout in progress; done : completion pulse
// Revision    : 1.0 - initial release
// ============================================================================
module cflog_reader #(
    parameter logic [15:0] LOG_SIZE = 16'h0100
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic [15:0] log_ptr,
    input  logic        abort,
    output logic        mem_rd_en,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rd_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_data,
    output logic        out_last,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HDR  = 3'd1,
        S_RD   = 3'd2,
        S_CAP  = 3'd3,
        S_SEND = 3'd4,
        S_TRL  = 3'd5,
        S_DONE = 3'd6
    } state_t;

    state_t      r_state;
    logic [15:0] r_len;
    logic [15:0] r_checksum;
    logic        r_flush_d;
    // Set once flush has been observed low since reset, so a flush that is
    // still high when reset releases is not mistaken for a fresh request.
    logic        r_flush_armed;

    logic [15:0] w_ptr_clamp;
    logic [15:0] w_len;
    logic [15:0] w_next_addr;
    logic        w_start;
    logic        w_xfer;

    assign w_ptr_clamp = (log_ptr > LOG_SIZE) ? LOG_SIZE : log_ptr;
    assign w_len       = w_ptr_clamp & 16'hFFFE;
    assign w_next_addr = mem_addr + 16'd2;
    assign w_start     = flush & ~r_flush_d & r_flush_armed;
    assign w_xfer      = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_len         <= 16'd0;
            r_checksum    <= 16'd0;
            r_flush_d     <= 1'b0;
            r_flush_armed <= 1'b0;
            mem_rd_en     <= 1'b0;
            mem_addr      <= 16'd0;
            out_valid     <= 1'b0;
            out_data      <= 16'd0;
            out_last      <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
        end else begin
            r_flush_d <= flush;
            if (!flush) begin
                r_flush_armed <= 1'b1;
            end

            if (abort && (r_state != S_IDLE)) begin
                // Abort overrides any handshake in the same cycle and drops
                // the stream word immediately.
                r_state    <= S_IDLE;
                r_checksum <= 16'd0;
                mem_rd_en  <= 1'b0;
                out_valid  <= 1'b0;
                out_data   <= 16'd0;
                out_last   <= 1'b0;
                busy       <= 1'b0;
                done       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_len      <= w_len;
                            out_data   <= {1'b0, w_len[15:1]};
                            r_checksum <= {1'b0, w_len[15:1]};
                            out_valid  <= 1'b1;
                            out_last   <= 1'b0;
                            busy       <= 1'b1;
                            r_state    <= S_HDR;
                        end
                    end
                    S_HDR: begin
                        if (w_xfer) begin
                            if (r_len == 16'd0) begin
                                out_data <= r_checksum;
                                out_last <= 1'b1;
                                r_state  <= S_TRL;
                            end else begin
                                out_valid <= 1'b0;
                                mem_addr  <= 16'd0;
                                mem_rd_en <= 1'b1;
                                r_state   <= S_RD;
                            end
                        end
                    end
                    S_RD: begin
                        mem_rd_en <= 1'b0;
                        r_state   <= S_CAP;
                    end
                    S_CAP: begin
                        out_data  <= mem_rd_data;
                        out_valid <= 1'b1;
                        r_state   <= S_SEND;
                    end
                    S_SEND: begin
                        if (w_xfer) begin
                            r_checksum <= r_checksum ^ out_data;
                            if (w_next_addr == r_len) begin
                                // Last entry: trailer carries the final XOR,
                                // valid stays high into TRL.
                                out_data <= r_checksum ^ out_data;
                                out_last <= 1'b1;
                                r_state  <= S_TRL;
                            end else begin
                                out_valid <= 1'b0;
                                mem_addr  <= w_next_addr;
                                mem_rd_en <= 1'b1;
                                r_state   <= S_RD;
                            end
                        end
                    end
                    S_TRL: begin
                        if (w_xfer) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            done      <= 1'b1;
                            r_state   <= S_DONE;
                        end
                    end
                    S_DONE: begin
                        done    <= 1'b0;
                        busy    <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/cflog_reader.md
Name: cflog_reader

Overview:
- Read-side counterpart to the CF-Log writer (log monitor). On an attestation flush it reads the CF-Log memory from word 0 up to the captured log pointer.
- It streams the log out as 16-bit words over a valid/ready interface, in this order: header, entries, XOR checksum trailer.
- It sits between the CF-Log RAM read port and the attestation report/transmit path.

Parameters:
- LOG_SIZE, 16'h0100, CF-Log capacity in bytes; must be even.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- flush  input  1  log-flush request from the log monitor; the rising edge starts a readout.
- log_ptr  input  16  CF-Log byte pointer (cflow_log_ptr); sampled on the start cycle.
- abort  input  1  synchronous cancel of an in-progress readout.
- mem_rd_en  output  1  CF-Log RAM read strobe.
- mem_addr  output  16  CF-Log RAM byte address; always even.
- mem_rd_data  input  16  RAM read data; valid exactly 1 cycle after mem_rd_en.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accepts the word.
- out_data  output  16  stream word.
- out_last  output  1  marks the final word (the trailer).
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse after the trailer is accepted.

Behaviour:
- Reset (async): state=IDLE. mem_rd_en, out_valid, out_last, busy and done are all 0. out_data=0, mem_addr=0, checksum=0, flush_d=0.

Start:
- In IDLE, flush=1 with flush_d=0 (flush_d is flush registered every cycle) starts a readout.
- On the start cycle, len is captured as min(log_ptr, LOG_SIZE) with bit0 cleared.
- The start edge is ignored outside IDLE.

States and transitions:
- IDLE: wait for start -> HDR.
- HDR:
  - out_valid=1, out_data=len>>1 (entry count). checksum loads this word.
  - On handshake: if len==0 -> TRL, else -> RD with addr=0.
- RD:
  - mem_rd_en=1, mem_addr=addr for exactly 1 cycle -> CAP.
- CAP:
  - mem_rd_data is registered into out_data with out_valid=1 -> SEND.
  - The entry is presented in the cycle after CAP; 2-cycle read-to-valid latency.
- SEND:
  - Hold out_valid and out_data until out_ready.
  - On handshake: checksum ^= word, addr += 2.
  - If addr+2 == len -> TRL, else -> RD.
- TRL:
  - out_valid=1, out_last=1, out_data=checksum.
  - On handshake -> DONE.
- DONE: done=1 for one cycle -> IDLE.

Handshake rules:
- A transfer occurs when out_valid && out_ready.
- out_data and out_last must not change while out_valid=1 and no transfer has occurred.
- out_valid never depends combinationally on out_ready.

Throughput and latency:
- HDR valid 1 cycle after start.
- Minimum 3 cycles per entry (RD, CAP, SEND) with out_ready tied high.

Arithmetic:
- addr and len are 16-bit unsigned; addr never exceeds len-2.
- The checksum is the XOR of the header and all entries; the trailer itself is excluded.

Boundary conditions:
- log_ptr > LOG_SIZE: clamp to LOG_SIZE.
- Odd log_ptr: truncate to even.
- len==0: stream is header(0) followed by trailer(0). No memory reads occur.
- abort=1 in any non-IDLE state: next state is IDLE. out_valid drops even mid-word (the only exception to the hold rule). No done pulse. checksum clears.
- abort has priority over a simultaneous handshake.
- abort in IDLE: no effect.
- flush held high across completion: no restart until flush falls and rises again.
- reset mid-readout: immediate return to IDLE. No further mem_rd_en.
- Simultaneous start and abort in IDLE: the start wins, because abort applies only to non-IDLE states.

Test Plan:
1. reset; log_ptr=16'h0006, pulse flush; RAM[0,2,4]=16'hA000,16'h1234,16'h00FF; out_ready=1 -> stream 3, A000, 1234, 00FF, then trailer=16'hB2C8 with out_last=1; done pulses once; exactly 3 mem_rd_en pulses at addr 0, 2, 4.
2. log_ptr=0, flush -> header 0, trailer 0 (out_last=1); mem_rd_en never asserted; done pulses once.
3. Same stimulus as 1 with out_ready toggling 1-0-0-1 -> every word held stable while stalled; identical word sequence and trailer; no RAM re-read while stalled.
4. LOG_SIZE=16'h0008, log_ptr=16'h0013 -> header 4; reads at addr 0, 2, 4, 6 only; trailer = XOR of header and the 4 entries.
5. Assert abort while in SEND during the second entry -> out_valid=0 next cycle, busy=0, no done; a new flush edge restarts from the header with a fresh checksum.
6. Assert reset asynchronously mid-CAP -> all outputs 0 without a clock edge; flush held high afterwards causes no start until it deasserts and rises again.
